cargador_operandos_flotante: RTL and testbench

- Sequential front-end and result-capture stage for the combinational floating-point adder (sign + E exponent + M mantissa bits).
- Assembles operands A and B one 4-bit nibble at a time from board switches and drives them to the adder.
- Registers the adder's sum and exponent carry after the operands are stable, then holds the result for display with a done flag.
- Sits between the switch/button conditioning logic and the 7-segment/LED display logic.

---
 rtl/cargador_operandos_flotante.sv | 112 +++++++++++
 tb/tb_cargador_operandos_flotante.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cargador_operandos_flotante.sv
// rtl/cargador_operandos_flotante.sv - nibble-serial operand loader and result capture for the float adder
// Optional macro ACUMULAR_EN: a load in RESULTADO feeds the held sum back as operand A.
module cargador_operandos_flotante #(
  parameter  int E  = 8,
  parameter  int M  = 23,
  localparam int W  = E + M + 1,
  localparam int N  = (W + 3) / 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    dato_in,
  input  logic          cargar,
  input  logic          limpiar,
  output logic [W-1:0]  op_a,
  output logic [W-1:0]  op_b,
  input  logic [W-1:0]  s_in,
  input  logic          exp_cout_in,
  output logic [W-1:0]  resultado,
  output logic          desborde,
  output logic          listo,
  output logic [1:0]    estado,
  output logic [CW-1:0] conteo
);

  typedef enum logic [1:0] {
    CARGA_A   = 2'd0,
    CARGA_B   = 2'd1,
    SUMA      = 2'd2,
    RESULTADO = 2'd3
  } estado_t;

  estado_t st;
  logic    ultimo;

  assign estado = st;
  assign ultimo = (conteo == CW'(N - 1));

  // Nibbles arrive MSB first; anything pushed above bit W-1 falls off.
  function automatic logic [W-1:0] desplazar(input logic [W-1:0] v, input logic [3:0] n);
    logic [W+3:0] t;
    t = {v, n};
    return t[W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= CARGA_A;
      op_a      <= '0;
      op_b      <= '0;
      resultado <= '0;
      desborde  <= 1'b0;
      listo     <= 1'b0;
      conteo    <= '0;
    end else if (limpiar) begin
      st     <= CARGA_A;
      op_a   <= '0;
      op_b   <= '0;
      conteo <= '0;
      listo  <= 1'b0;
    end else begin
      case (st)
        CARGA_A: begin
          if (cargar) begin
            op_a <= desplazar(op_a, dato_in);
            if (ultimo) begin
              conteo <= '0;
              st     <= CARGA_B;
            end else begin
              conteo <= conteo + CW'(1);
            end
          end
        end
        CARGA_B: begin
          if (cargar) begin
            op_b <= desplazar(op_b, dato_in);
            if (ultimo) begin
              conteo <= '0;
              st     <= SUMA;
            end else begin
              conteo <= conteo + CW'(1);
            end
          end
        end
        SUMA: begin
          // Operands have been stable for this whole cycle, so the adder output is settled.
          resultado <= s_in;
          desborde  <= exp_cout_in;
          listo     <= 1'b1;
          st        <= RESULTADO;
        end
        RESULTADO: begin
          if (cargar) begin
`ifdef ACUMULAR_EN
            op_a <= resultado;
            op_b <= W'(dato_in);
            st   <= CARGA_B;
`else
            op_a <= W'(dato_in);
            op_b <= '0;
            st   <= CARGA_A;
`endif
            conteo <= CW'(1);
            listo  <= 1'b0;
          end
        end
        default: st <= CARGA_A;
      endcase
    end
  end

endmodule

// File: tb/tb_cargador_operandos_flotante.sv
// tb/tb_cargador_operandos_flotante.sv - table-driven bench for cargador_operandos_flotante
module tb_cargador_operandos_flotante;

  logic        clk = 1'b0;
  logic        rst, cargar, limpiar, exp_cout_in, desborde, listo;
  logic [3:0]  dato_in, conteo;
  logic [1:0]  estado;
  logic [31:0] op_a, op_b, s_in, resultado;

  int checks = 0;
  int errors = 0;
  int fila = 0;

  always #5 clk = ~clk;

  cargador_operandos_flotante #(.E(8), .M(23)) dut (
    .clk(clk), .rst(rst), .dato_in(dato_in), .cargar(cargar), .limpiar(limpiar),
    .op_a(op_a), .op_b(op_b), .s_in(s_in), .exp_cout_in(exp_cout_in),
    .resultado(resultado), .desborde(desborde), .listo(listo),
    .estado(estado), .conteo(conteo)
  );

  // Stand-in for the adder: exact sums for the operand pairs used here, a marker pattern otherwise.
  always_comb begin
    exp_cout_in = 1'b0;
    s_in        = op_a ^ op_b ^ 32'h5A5A_0000;
    if (op_a == 32'h3F80_0000 && op_b == 32'h4000_0000) s_in = 32'h4040_0000;
    else if (op_a == 32'h4040_0000 && op_b == 32'h3F80_0000) s_in = 32'h4080_0000;
    else if (op_a == 32'h7F00_0000 && op_b == 32'h7F00_0000) begin
      s_in        = 32'h7F80_0000;
      exp_cout_in = 1'b1;
    end
  end

  typedef struct {
    logic        r, c, l;
    logic [3:0]  d;
    logic [1:0]  e;
    logic [3:0]  n;
    logic        ls;
    logic [31:0] a, b, res;
    logic        ds;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic c, logic l, logic [3:0] d, logic [1:0] e,
                              logic [3:0] n, logic ls, logic [31:0] a, logic [31:0] b,
                              logic [31:0] res, logic ds);
    vec_t v;
    v.r = r; v.c = c; v.l = l; v.d = d; v.e = e; v.n = n; v.ls = ls;
    v.a = a; v.b = b; v.res = res; v.ds = ds;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, fila, act, exp);
    end
  endtask

  task automatic chk_all(input vec_t v);
    chk("estado", 32'(estado), 32'(v.e));
    chk("conteo", 32'(conteo), 32'(v.n));
    chk("listo", 32'(listo), 32'(v.ls));
    chk("op_a", op_a, v.a);
    chk("op_b", op_b, v.b);
    chk("resultado", resultado, v.res);
    chk("desborde", 32'(desborde), 32'(v.ds));
  endtask

  task automatic paso(input logic r, input logic c, input logic l, input logic [3:0] d);
    rst = r; cargar = c; limpiar = l; dato_in = d;
    @(negedge clk);
    rst = 1'b0; cargar = 1'b0; limpiar = 1'b0;
  endtask

  task automatic cargar_palabra(input logic [31:0] w);
    for (int k = 7; k >= 0; k--) paso(1'b0, 1'b1, 1'b0, w[k*4 +: 4]);
  endtask

  initial begin
    logic [31:0] acc;
    rst = 1'b0; cargar = 1'b0; limpiar = 1'b0; dato_in = 4'h0;

    vecs.push_back(mk(1, 0, 0, 4'h0, 2'd0, 4'd0, 0, 32'h0, 32'h0, 32'h0, 0));
    // Operand A = 1.0, nibble by nibble
    acc = 32'h3F80_0000;
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 1, 0, acc[28-4*k +: 4], (k == 7) ? 2'd1 : 2'd0,
                        (k == 7) ? 4'd0 : 4'(k + 1), 0, acc >> (28 - 4*k), 32'h0, 32'h0, 0));
    // Operand B = 2.0
    acc = 32'h4000_0000;
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 1, 0, acc[28-4*k +: 4], (k == 7) ? 2'd2 : 2'd1,
                        (k == 7) ? 4'd0 : 4'(k + 1), 0, 32'h3F80_0000, acc >> (28 - 4*k), 32'h0, 0));
    // SUMA with a stray cargar: ignored, result captured
    vecs.push_back(mk(0, 1, 0, 4'h5, 2'd3, 4'd0, 1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0));
    vecs.push_back(mk(0, 0, 0, 4'h9, 2'd3, 4'd0, 1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0));
`ifndef ACUMULAR_EN
    vecs.push_back(mk(0, 1, 0, 4'h4, 2'd0, 4'd1, 0, 32'h4, 32'h0, 32'h4040_0000, 0));
    for (int k = 1; k < 8; k++)
      vecs.push_back(mk(0, 1, 0, 4'h0, (k == 7) ? 2'd1 : 2'd0, (k == 7) ? 4'd0 : 4'(k + 1),
                        0, 32'h4 << (4*k), 32'h0, 32'h4040_0000, 0));
    // Five nibbles of B, then abort
    acc = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      acc = (acc << 4) | 32'(k);
      vecs.push_back(mk(0, 1, 0, 4'(k), 2'd1, 4'(k), 0, 32'h4000_0000, acc, 32'h4040_0000, 0));
    end
    vecs.push_back(mk(0, 0, 1, 4'h0, 2'd0, 4'd0, 0, 32'h0, 32'h0, 32'h4040_0000, 0));
    // Three nibbles of A, then cargar+limpiar together
    vecs.push_back(mk(0, 1, 0, 4'hA, 2'd0, 4'd1, 0, 32'hA, 32'h0, 32'h4040_0000, 0));
    vecs.push_back(mk(0, 1, 0, 4'hB, 2'd0, 4'd2, 0, 32'hAB, 32'h0, 32'h4040_0000, 0));
    vecs.push_back(mk(0, 1, 0, 4'hC, 2'd0, 4'd3, 0, 32'hABC, 32'h0, 32'h4040_0000, 0));
    vecs.push_back(mk(0, 1, 1, 4'hD, 2'd0, 4'd0, 0, 32'h0, 32'h0, 32'h4040_0000, 0));
    vecs.push_back(mk(0, 0, 0, 4'hE, 2'd0, 4'd0, 0, 32'h0, 32'h0, 32'h4040_0000, 0));
`else
    // Running sum becomes A; B = 1.0 is loaded starting with the restart nibble
    acc = 32'h3F80_0000;
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 1, 0, acc[28-4*k +: 4], (k == 7) ? 2'd2 : 2'd1,
                        (k == 7) ? 4'd0 : 4'(k + 1), 0, 32'h4040_0000, acc >> (28 - 4*k),
                        32'h4040_0000, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 2'd3, 4'd0, 1, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 2'd0, 4'd0, 0, 32'h0, 32'h0, 32'h4080_0000, 0));
`endif

    @(negedge clk);
    foreach (vecs[i]) begin
      fila = i;
      paso(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].d);
      chk_all(vecs[i]);
    end

    // Exponent overflow captured alongside the sum
    fila = 1000;
    paso(1'b0, 1'b0, 1'b1, 4'h0);
    cargar_palabra(32'h7F00_0000);
    chk("ovf_op_a", op_a, 32'h7F00_0000);
    cargar_palabra(32'h7F00_0000);
    chk("ovf_suma_estado", 32'(estado), 32'd2);
    chk("ovf_listo_bajo", 32'(listo), 32'd0);
    paso(1'b0, 1'b0, 1'b0, 4'h0);
    chk("ovf_listo", 32'(listo), 32'd1);
    chk("ovf_desborde", 32'(desborde), 32'd1);
    chk("ovf_resultado", resultado, 32'h7F80_0000);
    paso(1'b0, 1'b0, 1'b1, 4'h0);
    chk("clr_desborde_kept", 32'(desborde), 32'd1);
    chk("clr_resultado_kept", resultado, 32'h7F80_0000);

    // Reset in the middle of loading A wipes everything
    fila = 2000;
    paso(1'b0, 1'b1, 1'b0, 4'h7);
    paso(1'b0, 1'b1, 1'b0, 4'h3);
    chk("pre_rst_conteo", 32'(conteo), 32'd2);
    paso(1'b1, 1'b1, 1'b0, 4'hF);
    chk_all(mk(0, 0, 0, 4'h0, 2'd0, 4'd0, 0, 32'h0, 32'h0, 32'h0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
